telemetry_framer: RTL and testbench

TELEMETRY_FRAMER -- requirements
Module: telemetry_framer

---
 rtl/telemetry_framer.sv | 174 +++++++++++++++++
 tb/tb_telemetry_framer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_framer.sv
// telemetry_framer
//   Periodically (or on command) snapshots NCH sensor channels and streams
//   them to a byte-wide UART transmitter as a framed packet:
//     HEADER, SEQ, ch0 bytes (MSB first) .. ch[NCH-1] bytes, CHK
//   CHK is the XOR of SEQ and every channel byte. A UART command byte stream
//   controls a buzzer, pauses periodic framing, or requests a frame.
//
// Ports
//   Clock       system clock, rising edge
//   Reset       asynchronous active-low reset
//   ch_data     channel k at bits [k*CHW +: CHW]
//   tx_data     byte offered to the transmitter
//   tx_valid    tx_data is valid; accepted when tx_ready is also high
//   tx_ready    transmitter ready
//   rx_data     received command byte
//   rx_valid    one-cycle strobe qualifying rx_data
//   buzzer      active-low buzzer drive
//   overrun_cnt saturating count of dropped frame triggers
module telemetry_framer #(
  parameter int         NCH    = 4,
  parameter int         CHW    = 16,
  parameter int         PERIOD = 5000000,
  parameter logic [7:0] HEADER = 8'h5A
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NCH*CHW-1:0] ch_data,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               buzzer,
  output logic [7:0]         overrun_cnt
);

  localparam int BPC  = CHW / 8;          // bytes per channel
  localparam int NB   = NCH * BPC;        // channel bytes per frame
  localparam int LAST = NB + 2;           // index of the CHK byte
  localparam int IW   = $clog2(LAST + 1);
  localparam int CW   = $clog2(PERIOD);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               paused_q, paused_d;
  logic               pending_q, pending_d;
  logic               buzzer_q, buzzer_d;
  logic [7:0]         ovr_q, ovr_d;
  logic [7:0]         seq_q;
  logic [7:0]         tx_data_q;
  logic               tx_valid_q;
  logic [IW-1:0]      idx_q;
  logic [NCH*CHW-1:0] snap_q;

  logic          tick, cmd_trig, trig, start, accept, last_byte;
  logic [IW-1:0] nidx;
  logic [7:0]    chk, next_byte;

  // Channel byte j of the frame payload: channels in order, MSB byte first.
  function automatic logic [7:0] chan_byte(input logic [NCH*CHW-1:0] v, input int j);
    return v[(j / BPC) * CHW + (BPC - 1 - (j % BPC)) * 8 +: 8];
  endfunction

  assign tick      = (cnt_q == CW'(PERIOD - 1));
  assign cmd_trig  = rx_valid && (rx_data == 8'hD0);
  // A tick and a D0 command in the same cycle are a single trigger.
  assign trig      = (tick && !paused_q) || cmd_trig;
  assign start     = (state_q == IDLE) && pending_q;
  assign accept    = tx_valid_q && tx_ready;
  assign last_byte = (idx_q == IW'(LAST));
  assign nidx      = idx_q + IW'(1);

  always_comb begin
    chk = seq_q;
    for (int j = 0; j < NB; j++) chk = chk ^ chan_byte(snap_q, j);
  end

  // Byte to present after the current one is accepted.
  always_comb begin
    next_byte = 8'h00;
    if (nidx == IW'(1)) begin
      next_byte = seq_q;
    end else if (nidx == IW'(LAST)) begin
      next_byte = chk;
    end else begin
      for (int j = 0; j < NB; j++)
        if (nidx == IW'(j + 2)) next_byte = chan_byte(snap_q, j);
    end
  end

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    // A trigger that finds pending already set is dropped and counted.
    ovr_d = ovr_q;
    if (trig && pending_q && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
    pending_d = start ? 1'b0 : (pending_q | trig);
    paused_d  = paused_q;
    buzzer_d  = buzzer_q;
    if (rx_valid) begin
      case (rx_data)
        8'h88:   buzzer_d = 1'b0;
        8'h99:   buzzer_d = 1'b1;
        8'hC0:   paused_d = 1'b1;
        8'hC1:   paused_d = 1'b0;
        8'hD0:   begin end
        default: buzzer_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q     <= '0;
      paused_q  <= 1'b0;
      pending_q <= 1'b0;
      buzzer_q  <= 1'b1;
      ovr_q     <= 8'h00;
    end else begin
      cnt_q     <= cnt_d;
      paused_q  <= paused_d;
      pending_q <= pending_d;
      buzzer_q  <= buzzer_d;
      ovr_q     <= ovr_d;
    end
  end

  // Frame FSM with registered byte/valid outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      seq_q      <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            state_q    <= SEND;
            idx_q      <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= HEADER;
          end
        end
        SEND: begin
          if (accept) begin
            if (last_byte) begin
              state_q    <= IDLE;
              tx_valid_q <= 1'b0;
              seq_q      <= seq_q + 8'd1;
            end else begin
              idx_q     <= nidx;
              tx_data_q <= next_byte;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Payload snapshot; only ever read while a frame it started is in flight.
  always_ff @(posedge Clock) begin
    if (start) snap_q <= ch_data;
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign buzzer      = buzzer_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_telemetry_framer.sv
module tb_telemetry_framer;

  localparam int NCH    = 2;
  localparam int CHW    = 16;
  localparam int PERIOD = 20;
  localparam int BPC    = CHW / 8;

  logic               Clock = 1'b0;
  logic               Reset;
  logic [NCH*CHW-1:0] ch_data;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               buzzer;
  logic [7:0]         overrun_cnt;

  telemetry_framer #(
    .NCH(NCH), .CHW(CHW), .PERIOD(PERIOD), .HEADER(8'h5A)
  ) dut (
    .Clock(Clock), .Reset(Reset), .ch_data(ch_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .buzzer(buzzer), .overrun_cnt(overrun_cnt)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: transaction-level view of the framer.
  int         m_cnt;
  bit         m_paused, m_pending, m_sending, m_buzzer;
  logic [7:0] m_seq, m_ovr;
  logic [7:0] m_frame[$];   // bytes of the frame in flight still to be accepted
  logic [7:0] got[$];       // bytes the DUT actually handed over

  logic [7:0] exp1 [7] = '{8'h5A, 8'h00, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'h40};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_paused = 0; m_pending = 0; m_sending = 0; m_buzzer = 1;
    m_seq = 8'h00; m_ovr = 8'h00;
    m_frame.delete();
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit trig, start;
    logic [7:0] b, c;
    if (!Reset) begin
      model_reset();
      return;
    end
    trig  = ((m_cnt == PERIOD - 1) && !m_paused) || (rx_valid && rx_data == 8'hD0);
    start = !m_sending && m_pending;
    if (trig && m_pending && m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
    m_pending = !start && (m_pending || trig);
    if (m_sending && tx_ready) begin
      void'(m_frame.pop_front());
      if (m_frame.size() == 0) begin
        m_sending = 0;
        m_seq = m_seq + 8'd1;
      end
    end
    if (start) begin
      c = m_seq;
      m_frame.push_back(8'h5A);
      m_frame.push_back(m_seq);
      for (int k = 0; k < NCH; k++)
        for (int i = BPC - 1; i >= 0; i--) begin
          b = ch_data[k*CHW + i*8 +: 8];
          m_frame.push_back(b);
          c = c ^ b;
        end
      m_frame.push_back(c);
      m_sending = 1;
    end
    if (rx_valid) begin
      case (rx_data)
        8'h88:   m_buzzer = 0;
        8'h99:   m_buzzer = 1;
        8'hC0:   m_paused = 1;
        8'hC1:   m_paused = 0;
        8'hD0:   begin end
        default: m_buzzer = 1;
      endcase
    end
    m_cnt = (m_cnt + 1) % PERIOD;
  endtask

  // One clock cycle: called at a falling edge with inputs applied.
  task automatic cyc();
    if (Reset && tx_valid && tx_ready) got.push_back(tx_data);
    model_step();
    @(posedge Clock);
    @(negedge Clock);
    check("tx_valid", tx_valid, m_sending);
    if (m_sending) check("tx_data", tx_data, m_frame[0]);
    check("buzzer", buzzer, m_buzzer);
    check("overrun_cnt", overrun_cnt, m_ovr);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    cyc();
    rx_valid = 0;
  endtask

  initial begin
    Reset = 1; tx_ready = 1; rx_valid = 0; rx_data = 8'h00;
    ch_data = {16'h1234, 16'hABCD};
    model_reset();
    #1 Reset = 0;
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_buzzer", buzzer, 1);
    check("rst_overrun", overrun_cnt, 8'h00);
    @(negedge Clock);
    repeat (3) cyc();
    Reset = 1;

    // First two periodic frames with the transmitter always ready.
    got.delete();
    for (int i = 0; i < 100 && got.size() < 14; i++) cyc();
    check("two_frames_seen", got.size() >= 14, 1);
    for (int i = 0; i < 7; i++) check($sformatf("frame1_byte%0d", i), got[i], exp1[i]);
    check("frame2_hdr", got[7], 8'h5A);
    check("frame2_seq", got[8], 8'h01);
    check("frame2_chk", got[13], 8'h41);

    // Back-pressure while CD is offered.
    for (int i = 0; i < 100 && !(tx_valid && tx_data == 8'hCD); i++) cyc();
    check("cd_offered", tx_valid && tx_data == 8'hCD, 1);
    tx_ready = 0;
    repeat (10) cyc();
    check("stall_data", tx_data, 8'hCD);
    check("stall_valid", tx_valid, 1);
    tx_ready = 1;
    cyc();
    check("resume_data", tx_data, 8'h12);

    // Long stall from the first HEADER offer: one kept trigger, one dropped.
    Reset = 0; cyc(); Reset = 1;
    for (int i = 0; i < 100 && !tx_valid; i++) cyc();
    check("hdr_offer", tx_data, 8'h5A);
    tx_ready = 0;
    repeat (45) cyc();
    check("overrun_one", overrun_cnt, 8'd1);
    tx_ready = 1;
    got.delete();
    repeat (16) cyc();
    check("extra_frame_len", got.size(), 14);
    check("extra_frame_hdr", got[7], 8'h5A);
    check("extra_frame_seq", got[8], 8'h01);

    // Command decoding.
    send_cmd(8'h88);
    check("buz_88", buzzer, 0);
    send_cmd(8'hC0);
    repeat (30) cyc();
    got.delete();
    repeat (60) cyc();
    check("paused_no_frames", got.size(), 0);
    send_cmd(8'hD0);
    repeat (12) cyc();
    check("d0_frame_len", got.size(), 7);
    check("d0_frame_hdr", got[0], 8'h5A);
    send_cmd(8'h55);
    check("buz_other", buzzer, 1);
    send_cmd(8'h88);
    send_cmd(8'hC1);
    check("buz_c1_keeps", buzzer, 0);
    send_cmd(8'h99);
    check("buz_99", buzzer, 1);
    send_cmd(8'hC0);

    // Overrun saturation under a flood of D0 with the transmitter blocked.
    tx_ready = 0;
    rx_data = 8'hD0; rx_valid = 1;
    repeat (300) cyc();
    rx_valid = 0;
    check("overrun_sat", overrun_cnt, 8'hFF);
    tx_ready = 1;
    repeat (20) cyc();
    send_cmd(8'hC1);

    // Reset while byte 12 is offered.
    for (int i = 0; i < 100 && !(tx_valid && tx_data == 8'h12); i++) cyc();
    check("b12_offered", tx_valid && tx_data == 8'h12, 1);
    Reset = 0;
    #1;
    check("midrst_valid", tx_valid, 0);
    check("midrst_data", tx_data, 8'h00);
    check("midrst_buzzer", buzzer, 1);
    check("midrst_overrun", overrun_cnt, 8'h00);
    cyc(); cyc();
    Reset = 1;
    got.delete();
    for (int i = 0; i < 100 && got.size() < 2; i++) cyc();
    check("restart_hdr", got[0], 8'h5A);
    check("restart_seq", got[1], 8'h00);

    // D0 in the same cycle as a tick while nothing is pending.
    for (int i = 0; i < 100 && !(m_cnt == PERIOD - 1 && !m_pending && !m_sending); i++) cyc();
    got.delete();
    send_cmd(8'hD0);
    repeat (12) cyc();
    check("coinc_overrun", overrun_cnt, 8'h00);
    check("coinc_one_frame", got.size(), 7);

    // Randomized traffic: changing channels, back-pressure, commands.
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < NCH; k++) ch_data[k*CHW +: CHW] = CHW'($urandom);
      tx_ready = ($urandom_range(3) != 0);
      rx_valid = ($urandom_range(19) == 0);
      case ($urandom_range(5))
        0:       rx_data = 8'h88;
        1:       rx_data = 8'h99;
        2:       rx_data = 8'hC0;
        3:       rx_data = 8'hC1;
        4:       rx_data = 8'hD0;
        default: rx_data = 8'($urandom);
      endcase
      cyc();
    end
    rx_valid = 0;
    tx_ready = 1;
    send_cmd(8'hC1);

    // SEQ wrap FF -> 00.
    ch_data = {16'h1234, 16'hABCD};
    for (int i = 0; i < 8000 && !(m_seq == 8'hFF && !m_sending); i++) cyc();
    got.delete();
    for (int i = 0; i < 200 && got.size() < 14; i++) cyc();
    check("wrap_hdr_a", got[0], 8'h5A);
    check("wrap_seq_ff", got[1], 8'hFF);
    check("wrap_hdr_b", got[7], 8'h5A);
    check("wrap_seq_00", got[8], 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
